// File: rtl/register_file.sv
// Register file with a per-register pending scoreboard for an in-order RISC-V core.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
//
// Ports:
//   clk                 sole clock, all state updates on its rising edge
//   rst                 asynchronous active-low reset
//   wb_en/addr/data     write-back strobe, destination register and value
//   iss_en/addr         issue strobe and destination register to mark as pending
//   rs1_addr, rs2_addr  read addresses
//   rs1_data, rs2_data  read values (combinational)
//   rs1_busy, rs2_busy  high while the addressed register is pending
//   stall               rs1_busy | rs2_busy
module register_file #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              iss_en,
  input  logic [4:0]        iss_addr,
  input  logic [4:0]        rs1_addr,
  input  logic [4:0]        rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              stall
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [DATA_W-1:0] mem [NREG];
  logic [NREG-1:0]   pend;

  // x0 and any address at or beyond NREG behave as the zero register.
  function automatic logic legal(input logic [4:0] a);
    return (a != 5'd0) && ({27'd0, a} < 32'(NREG));
  endfunction

  logic          wb_ok;
  logic          iss_ok;
  logic          rs1_ok;
  logic          rs2_ok;
  logic [AW-1:0] wb_idx;
  logic [AW-1:0] iss_idx;
  logic [AW-1:0] rs1_idx;
  logic [AW-1:0] rs2_idx;

  assign wb_ok   = wb_en && legal(wb_addr);
  assign iss_ok  = iss_en && legal(iss_addr);
  assign rs1_ok  = legal(rs1_addr);
  assign rs2_ok  = legal(rs2_addr);
  assign wb_idx  = wb_addr[AW-1:0];
  assign iss_idx = iss_addr[AW-1:0];
  assign rs1_idx = rs1_addr[AW-1:0];
  assign rs2_idx = rs2_addr[AW-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
      pend <= '0;
    end else begin
      if (wb_ok) begin
        mem[wb_idx]  <= wb_data;
        pend[wb_idx] <= 1'b0;
      end
      // Issue after write-back so a same-cycle collision leaves it pending.
      if (iss_ok) begin
        pend[iss_idx] <= 1'b1;
      end
    end
  end

  always_comb begin
    rs1_data = '0;
    rs1_busy = 1'b0;
    if (rs1_ok) begin
      rs1_data = mem[rs1_idx];
      rs1_busy = pend[rs1_idx];
`ifdef REGFILE_BYPASS_EN
      if (wb_ok && (wb_addr == rs1_addr)) begin
        rs1_data = wb_data;
        rs1_busy = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    rs2_data = '0;
    rs2_busy = 1'b0;
    if (rs2_ok) begin
      rs2_data = mem[rs2_idx];
      rs2_busy = pend[rs2_idx];
`ifdef REGFILE_BYPASS_EN
      if (wb_ok && (wb_addr == rs2_addr)) begin
        rs2_data = wb_data;
        rs2_busy = 1'b0;
      end
`endif
    end
  end

  assign stall = rs1_busy | rs2_busy;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized
// traffic against an array-based reference model.
module tb_register_file;

  localparam int DW = 32;
  localparam int NR = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_en;
  logic [4:0]    wb_addr;
  logic [DW-1:0] wb_data;
  logic          iss_en;
  logic [4:0]    iss_addr;
  logic [4:0]    rs1_addr;
  logic [4:0]    rs2_addr;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;
  logic          rs1_busy;
  logic          rs2_busy;
  logic          stall;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] m_mem [32];
  bit            m_pend [32];

  register_file #(.DATA_W(DW), .NREG(NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .stall    (stall)
  );

  always #5 clk = ~clk;

  function automatic bit legal(input logic [4:0] a);
    return (a != 0) && (int'(a) < NR);
  endfunction

  function automatic bit byp_hit(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
    return rst && wb_en && legal(wb_addr) && (wb_addr == a);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [4:0] a);
    if (!legal(a)) return '0;
    if (byp_hit(a)) return wb_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (!legal(a)) return 1'b0;
    if (byp_hit(a)) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      if (wb_en && legal(wb_addr)) begin
        m_mem[wb_addr]  = wb_data;
        m_pend[wb_addr] = 1'b0;
      end
      if (iss_en && legal(iss_addr)) m_pend[iss_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    wb_en  = 1'b0;
    iss_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; m_clear();
    wb_en = 1'b1; wb_addr = 5; wb_data = 32'hDEADBEEF;
    iss_en = 1'b1; iss_addr = 5;
    rs1_addr = 5; rs2_addr = 5;
    tick();
    tests++;
    if (rs1_data !== 0 || rs2_data !== 0) begin
      fails++;
      $display("FAIL reset_data: got %h/%h want 0", rs1_data, rs2_data);
    end
    tests++;
    if (rs1_busy !== 0 || rs2_busy !== 0 || stall !== 0) begin
      fails++;
      $display("FAIL reset_busy: got %b%b%b want 000", rs1_busy, rs2_busy, stall);
    end
    idle();
    #2 rst = 1'b1;
    tick();
    tests++;
    if (rs1_data !== 0) begin
      fails++;
      $display("FAIL reset_release: got %h want 0", rs1_data);
    end
  endtask

  task automatic test_basic_write();
    wb_en = 1'b1; wb_addr = 7; wb_data = 32'h12345678;
    tick();
    idle();
    rs1_addr = 7; rs2_addr = 0;
    #1;
    tests++;
    if (rs1_data !== 32'h12345678 || rs2_data !== 0) begin
      fails++;
      $display("FAIL basic_write: got %h/%h want 12345678/0", rs1_data, rs2_data);
    end
  endtask

  task automatic test_x0();
    wb_en = 1'b1; wb_addr = 0; wb_data = 32'hFFFFFFFF;
    iss_en = 1'b1; iss_addr = 0;
    tick();
    idle();
    rs1_addr = 0;
    #1;
    tests++;
    if (rs1_data !== 0 || rs1_busy !== 0) begin
      fails++;
      $display("FAIL x0: got %h busy %b want 0 busy 0", rs1_data, rs1_busy);
    end
  endtask

  task automatic test_scoreboard();
    iss_en = 1'b1; iss_addr = 3;
    tick();
    idle();
    rs1_addr = 0; rs2_addr = 3;
    #1;
    tests++;
    if (rs2_busy !== 1'b1 || stall !== 1'b1) begin
      fails++;
      $display("FAIL sb_pending: got busy %b stall %b want 1 1", rs2_busy, stall);
    end
    wb_en = 1'b1; wb_addr = 3; wb_data = 32'hA5;
    tick();
    idle();
    #1;
    tests++;
    if (rs2_busy !== 0 || stall !== 0 || rs2_data !== 32'hA5) begin
      fails++;
      $display("FAIL sb_release: got %h busy %b stall %b want a5 0 0",
               rs2_data, rs2_busy, stall);
    end
  endtask

  task automatic test_simultaneous();
    iss_en = 1'b1; iss_addr = 9;
    wb_en = 1'b1; wb_addr = 9; wb_data = 32'h55;
    tick();
    idle();
    rs1_addr = 9;
    #1;
    tests++;
    if (rs1_data !== 32'h55 || rs1_busy !== 1'b1) begin
      fails++;
      $display("FAIL simultaneous: got %h busy %b want 55 busy 1", rs1_data, rs1_busy);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] want;
    logic          wbusy;
    wb_en = 1'b1; wb_addr = 4; wb_data = 32'h1111;
    iss_en = 1'b1; iss_addr = 4;
    tick();
    iss_en = 1'b0;
    wb_data = 32'hCAFE;
    rs1_addr = 4;
    #1;
`ifdef REGFILE_BYPASS_EN
    want = 32'hCAFE; wbusy = 1'b0;
`else
    want = 32'h1111; wbusy = 1'b1;
`endif
    tests++;
    if (rs1_data !== want || rs1_busy !== wbusy) begin
      fails++;
      $display("FAIL bypass_same: got %h busy %b want %h busy %b",
               rs1_data, rs1_busy, want, wbusy);
    end
    tick();
    idle();
    #1;
    tests++;
    if (rs1_data !== 32'hCAFE || rs1_busy !== 0) begin
      fails++;
      $display("FAIL bypass_next: got %h busy %b want cafe 0", rs1_data, rs1_busy);
    end
  endtask

  task automatic test_range();
    wb_en = 1'b1; wb_addr = 5'(NR); wb_data = 32'hBAD0BAD0;
    iss_en = 1'b1; iss_addr = 5'(NR);
    tick();
    wb_addr = 5'(NR - 1); wb_data = 32'h0BE11;
    iss_addr = 31;
    tick();
    idle();
    rs1_addr = 5'(NR); rs2_addr = 5'(NR - 1);
    #1;
    tests++;
    if (rs1_data !== 0 || rs1_busy !== 0) begin
      fails++;
      $display("FAIL range_high: got %h busy %b want 0 0", rs1_data, rs1_busy);
    end
    tests++;
    if (rs2_data !== 32'h0BE11 || rs2_busy !== 0) begin
      fails++;
      $display("FAIL range_top: got %h busy %b want be11 0", rs2_data, rs2_busy);
    end
  endtask

  task automatic test_reset_mid();
    wb_en = 1'b1; wb_addr = 6; wb_data = 32'h600D;
    iss_en = 1'b1; iss_addr = 6;
    tick();
    rs1_addr = 6; rs2_addr = 7;
    #2 rst = 1'b0;
    m_clear();
    #1;
    tests++;
    if (rs1_data !== 0 || rs2_data !== 0 || stall !== 0) begin
      fails++;
      $display("FAIL reset_async: got %h/%h stall %b want 0/0 0",
               rs1_data, rs2_data, stall);
    end
    tick();
    tests++;
    if (rs1_data !== 0 || rs1_busy !== 0) begin
      fails++;
      $display("FAIL reset_hold: got %h busy %b want 0 0", rs1_data, rs1_busy);
    end
    iss_en = 1'b0;
    wb_data = 32'h77;
    #2 rst = 1'b1;
    tick();
    idle();
    #1;
    tests++;
    if (rs1_data !== 32'h77 || rs1_busy !== 0) begin
      fails++;
      $display("FAIL reset_first_edge: got %h busy %b want 77 0", rs1_data, rs1_busy);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      wb_en    = ($urandom_range(0, 2) != 0);
      wb_addr  = 5'($urandom_range(0, 31));
      wb_data  = $urandom;
      iss_en   = ($urandom_range(0, 2) == 0);
      iss_addr = (n % 5 == 0) ? wb_addr : 5'($urandom_range(0, 31));
      rs1_addr = (n % 3 == 0) ? wb_addr : 5'($urandom_range(0, 31));
      rs2_addr = 5'($urandom_range(0, 31));
      #1;
      tests++;
      if (rs1_data !== exp_data(rs1_addr) || rs1_busy !== exp_busy(rs1_addr)) begin
        fails++;
        $display("FAIL rand_rs1 x%0d: got %h/%b want %h/%b", rs1_addr,
                 rs1_data, rs1_busy, exp_data(rs1_addr), exp_busy(rs1_addr));
      end
      tests++;
      if (rs2_data !== exp_data(rs2_addr) || rs2_busy !== exp_busy(rs2_addr)) begin
        fails++;
        $display("FAIL rand_rs2 x%0d: got %h/%b want %h/%b", rs2_addr,
                 rs2_data, rs2_busy, exp_data(rs2_addr), exp_busy(rs2_addr));
      end
      tests++;
      if (stall !== (exp_busy(rs1_addr) | exp_busy(rs2_addr))) begin
        fails++;
        $display("FAIL rand_stall: got %b want %b", stall,
                 exp_busy(rs1_addr) | exp_busy(rs2_addr));
      end
      tick();
    end
    idle();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    wb_addr = 0; wb_data = 0; iss_addr = 0;
    rs1_addr = 0; rs2_addr = 0;
    m_clear();
    #1;
    test_reset();
    test_basic_write();
    test_x0();
    test_scoreboard();
    test_simultaneous();
    test_bypass();
    test_range();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter NREG, default 32, number of architectural registers; address width is 5, fixed.
REQ-003 SHALL have port clk, input, 1, sole clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port wb_en, input, 1, write-back strobe.
REQ-006 SHALL have port wb_addr, input, 5, write-back destination register.
REQ-007 SHALL have port wb_data, input, DATA_W, write-back value.
REQ-008 SHALL have port iss_en, input, 1, issue strobe that marks the destination register as pending.
REQ-009 SHALL have port iss_addr, input, 5, destination register of the issuing instruction.
REQ-010 SHALL have ports rs1_addr and rs2_addr, input, 5 each, read addresses.
REQ-011 SHALL have ports rs1_data and rs2_data, output, DATA_W each, read values.
REQ-012 SHALL have ports rs1_busy and rs2_busy, output, 1 each, high when the addressed register is pending.
REQ-013 SHALL have port stall, output, 1, equal to rs1_busy OR rs2_busy.

Function
REQ-014 SHALL drive reads combinationally from current storage with zero-cycle latency.
REQ-015 SHALL write wb_data into register wb_addr on the rising clk edge when wb_en=1 and wb_addr!=0.
REQ-016 SHALL hold register x0 at 0, return 0 on any read of address 0, and ignore writes to address 0.
REQ-017 SHALL keep a per-register pending bit; the bit sets on the clk edge when iss_en=1 and iss_addr!=0.
REQ-018 SHALL clear the pending bit of wb_addr on the clk edge when wb_en=1.
REQ-019 SHALL keep the pending bit of x0 permanently 0.
REQ-020 SHALL give set priority when iss_en and wb_en target the same nonzero address in one cycle: data is written and the pending bit ends set.
REQ-021 SHALL drive rsN_busy from the registered pending bit of rsN_addr, with rsN_busy=0 when rsN_addr=0.
REQ-022 SHALL leave contents unchanged when wb_en=0, with no overflow or wrap effects.
REQ-023 SHALL treat addresses of NREG or more, when NREG<32, as x0: reads return 0, writes are ignored and busy is 0.

Reset
REQ-024 SHALL clear all registers and all pending bits asynchronously while rst=0, with rs1_data=rs2_data=0, busy=0 and stall=0.
REQ-025 SHALL abort any pending state on reset mid-operation; the first edge after rst rises performs normal writes.
REQ-026 SHALL ignore wb_en and iss_en while rst=0.

Configuration
REQ-027 SHALL support the macro REGFILE_BYPASS_EN.
REQ-028 SHALL, with REGFILE_BYPASS_EN defined, make a read of rsN_addr==wb_addr!=0 with wb_en=1 return wb_data in the same cycle and force rsN_busy=0 (unless the same cycle's iss_en targets it after the edge).
REQ-029 SHALL, without REGFILE_BYPASS_EN, return the old stored value during the write cycle and the new value from the next cycle onward.

Verification
REQ-030 SHALL cover reset: hold rst=0 and write x5=32'hDEADBEEF -> read x5=0, busy=0, stall=0.
REQ-031 SHALL cover basic write: wb x7=32'h12345678, then read rs1=7, rs2=0 next cycle -> rs1_data=32'h12345678, rs2_data=0.
REQ-032 SHALL cover x0 protection: wb x0=32'hFFFFFFFF, iss x0 -> rs1 of x0 reads 0, rs1_busy=0.
REQ-033 SHALL cover the scoreboard: iss x3, read rs2=3 -> rs2_busy=1, stall=1; wb x3=32'hA5 -> next cycle busy=0, data=32'hA5.
REQ-034 SHALL cover simultaneous events: iss x9 and wb x9=32'h55 in one cycle -> next cycle data=32'h55, rs1_busy=1.
REQ-035 SHALL cover bypass: same-cycle wb x4=32'hCAFE and read rs1=4 -> 32'hCAFE with REGFILE_BYPASS_EN, old value without it.
